// File: rtl/instr_decode_stage.sv
// instr_decode_stage: registered RV32 decode stage. Classifies each fetched
// instruction by format, extracts register/funct fields and the sign-extended
// immediate, flags illegal encodings, and queues the decoded records in a
// DEPTH-entry FIFO ahead of execute.
module instr_decode_stage #(
  parameter int unsigned DEPTH    = 2,
  parameter bit          ENABLE_M = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [6:0]  out_opcode,
  output logic [2:0]  out_type,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [2:0]  out_funct3,
  output logic [6:0]  out_funct7,
  output logic [31:0] out_imm,
  output logic        out_illegal
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_SB   = 3'd3,
    FMT_U    = 3'd4,
    FMT_UJ   = 3'd5,
    FMT_NONE = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    fmt_e        fmt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        illegal;
  } rec_t;

  rec_t dec;
  rec_t head;

  rec_t            mem_q [DEPTH];
  rec_t            mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            in_ready_q, in_ready_d;
  logic            push, pop;

  // Combinational decode of the incoming word into a FIFO record
  always_comb begin
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    fmt_e       fmt;
    logic       ill;

    opc = in_instr[6:0];
    f3  = in_instr[14:12];
    f7  = in_instr[31:25];

    case (opc)
      7'b0000011, 7'b0001111, 7'b0010011,
      7'b1100111, 7'b1110011:             fmt = FMT_I;
      7'b0010111, 7'b0110111:             fmt = FMT_U;
      7'b0100011:                         fmt = FMT_S;
      7'b0110011:                         fmt = FMT_R;
      7'b1100011:                         fmt = FMT_SB;
      7'b1101111:                         fmt = FMT_UJ;
      default:                            fmt = FMT_NONE;
    endcase

    ill = (in_instr[1:0] != 2'b11) || (fmt == FMT_NONE);
    if (fmt == FMT_R) begin
      if (f7 == 7'b0100000) begin
        if (f3 != 3'b000 && f3 != 3'b101) ill = 1'b1;
      end else if (f7 == 7'b0000001) begin
        if (!ENABLE_M) ill = 1'b1;
      end else if (f7 != 7'b0000000) begin
        ill = 1'b1;
      end
    end

    dec        = '0;
    dec.pc     = in_pc;
    dec.opcode = opc;
    dec.fmt    = fmt;

    case (fmt)
      FMT_R: begin
        dec.rd     = in_instr[11:7];
        dec.rs1    = in_instr[19:15];
        dec.rs2    = in_instr[24:20];
        dec.funct3 = f3;
        dec.funct7 = f7;
      end
      FMT_I: begin
        dec.rd     = in_instr[11:7];
        dec.rs1    = in_instr[19:15];
        dec.funct3 = f3;
        dec.imm    = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      FMT_S: begin
        dec.rs1    = in_instr[19:15];
        dec.rs2    = in_instr[24:20];
        dec.funct3 = f3;
        dec.imm    = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      FMT_SB: begin
        dec.rs1    = in_instr[19:15];
        dec.rs2    = in_instr[24:20];
        dec.funct3 = f3;
        dec.imm    = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                      in_instr[30:25], in_instr[11:8], 1'b0};
      end
      FMT_U: begin
        dec.rd     = in_instr[11:7];
        dec.imm    = {in_instr[31:12], 12'b0};
      end
      FMT_UJ: begin
        dec.rd     = in_instr[11:7];
        dec.imm    = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                      in_instr[20], in_instr[30:21], 1'b0};
      end
      default: ;
    endcase

    // Illegal records keep only pc and opcode so execute sees a clean trap record
    if (ill) begin
      dec         = '0;
      dec.pc      = in_pc;
      dec.opcode  = opc;
      dec.fmt     = FMT_NONE;
      dec.illegal = 1'b1;
    end
  end

  // FIFO next-state: flush wins over push/pop; in_ready is precomputed from count_d
  always_comb begin
    push       = in_valid && in_ready_q && !flush;
    pop        = (count_q != '0) && out_ready && !flush;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = dec;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
    in_ready_d = (count_d < DEPTH_C);
  end

  // Control state with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Record storage; contents are don't-care while count is zero
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Head record drives outputs; fields read as zero whenever the FIFO is empty
  always_comb begin
    head = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (count_q != '0);
  assign out_pc      = head.pc;
  assign out_opcode  = head.opcode;
  assign out_type    = head.fmt;
  assign out_rd      = head.rd;
  assign out_rs1     = head.rs1;
  assign out_rs2     = head.rs2;
  assign out_funct3  = head.funct3;
  assign out_funct7  = head.funct7;
  assign out_imm     = head.imm;
  assign out_illegal = head.illegal;

endmodule

// File: doc/instr_decode_stage.md
Name: instr_decode_stage

Overview:
- Registered, parametrised RV32 instruction-decode stage between fetch and execute.
- Accepts raw instructions with their PC over a valid/ready handshake and classifies each one by format (R/I/S/SB/U/UJ).
- Extracts register and function fields, produces a fully sign-extended immediate and flags illegal encodings.
- Buffers decoded records in a DEPTH-entry FIFO so fetch is decoupled from execute stalls, with synchronous flush for branches and traps.

Parameters:
- DEPTH, 2, number of decoded-record FIFO entries; power of two, minimum 2.
- ENABLE_M, 0, 1 = R-type with funct7=7'b0000001 (RV32M) is legal.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; discards all buffered records and any same-cycle input.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept an instruction.
- in_instr  in  32  raw instruction.
- in_pc  in  32  instruction address.
- out_valid  out  1  head record is valid.
- out_ready  in  1  execute consumes the head record.
- out_pc  out  32  PC of the head record.
- out_opcode  out  7  instr[6:0].
- out_type  out  3  format: R=0, I=1, S=2, SB=3, U=4, UJ=5, NONE=7.
- out_rd, out_rs1, out_rs2  out  5 each  register ids; 0 where the format has no such field.
- out_funct3  out  3  0 where the format has no such field.
- out_funct7  out  7  0 where the format has no such field.
- out_imm  out  32  sign-extended immediate; 0 for R-type.
- out_illegal  out  1  head record is an illegal encoding.

Behaviour:
- Reset: rst asserted clears count and both pointers; in_ready=1, out_valid=0, all out_* data fields 0. Release takes effect on the next edge.
- Decode is combinational on in_instr. The decoded record, not the raw word, is written into the FIFO.
- Opcode map:
  - 0000011, 0001111, 0010011, 1100111, 1110011 -> I
  - 0010111, 0110111 -> U
  - 0100011 -> S
  - 0110011 -> R
  - 1100011 -> SB
  - 1101111 -> UJ
  - anything else -> NONE
- Immediates:
  - I: sext(instr[31:20])
  - S: sext({instr[31:25], instr[11:7]})
  - SB: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0})
  - U: {instr[31:12], 12'b0}
  - UJ: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0})
- Illegal when any of the following holds:
  - instr[1:0] != 2'b11
  - type NONE
  - R-type with funct7 not in {0000000, 0100000}, except funct7=0000001 when ENABLE_M=1
  - R-type with funct7=0100000 and funct3 not in {000, 101}
- Illegal records: type=7 and all register, funct and immediate fields 0; opcode and pc preserved; out_illegal=1.
- Handshake:
  - Push when in_valid && in_ready. Pop when out_valid && out_ready.
  - in_ready = (count < DEPTH), registered; it never depends combinationally on out_ready.
  - When full, in_ready=0 even if a pop occurs in the same cycle.
  - out_valid = (count != 0). Output fields come from the head entry and stay stable while out_valid && !out_ready.
- Latency: an instruction accepted at edge N is visible on the outputs after edge N, provided the FIFO was empty. There is no combinational in-to-out path.
- Simultaneous push and pop when 0 < count < DEPTH: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- Flush has priority over push and pop: count=0, pointers=0, the same-cycle input is dropped, out_valid=0 next cycle.
- Asserting rst mid-stream discards all entries immediately, asynchronously.

Test Plan:
- 0xFFF00093 (addi x1,x0,-1) with out_ready=1 -> next cycle: type=1, rd=1, rs1=0, funct3=0, imm=0xFFFFFFFF, illegal=0.
- 0x0020A423 (sw x2,8(x1)), then 0xFFDFF0EF (jal x1,-4) -> first: type=2, rs1=1, rs2=2, imm=8; second: type=5, rd=1, imm=0xFFFFFFFC.
- 0x123452B7 (lui x5,0x12345) -> type=4, rd=5, imm=0x12345000. Then 0x022081B3 (mul): ENABLE_M=1 -> type=0, funct7=1, illegal=0; ENABLE_M=0 -> illegal=1, type=7.
- 0x00000000 and opcode 0x7F -> illegal=1, imm=0, rd=0.
- DEPTH=2, out_ready=0, three pushes offered -> in_ready falls after the second push and the third is held. Then out_ready=1 -> records drain in order, in_ready returns, the third is accepted.
- Two entries buffered, flush asserted together with in_valid=1 -> next cycle out_valid=0, count=0, the input is not stored. Repeat using rst mid-stream -> outputs 0 immediately.
